// File: rtl/ddram_pkg.sv
// Shared types and helpers for the DDRAM ROM write channel.
// State codes are plain constants so legacy netlists can name them directly.
package ddram_pkg;

    localparam int DDRAM_AW  = 29;
    localparam int DDRAM_DW  = 64;
    localparam int DDRAM_BEW = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t WRITE   = 2'd2;
    localparam state_t FINISH  = 2'd3;

    // 64-bit word address of a region byte, given the byte offset divided by 8.
    function automatic logic [DDRAM_AW-1:0] word_addr(
        input logic [DDRAM_AW-1:0] base,
        input logic [21:0]         word_off
    );
        return base + {{(DDRAM_AW-22){1'b0}}, word_off};
    endfunction

endpackage

// File: rtl/ddram_rom_writer_byte_packer.sv
// Packs accepted download bytes into one 64-bit word with a lane mask,
// plus a one-entry skid slot for a byte that belongs to the next word.
module ddram_rom_writer_byte_packer
    import ddram_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [DDRAM_AW-1:0]  in_addr,
    input  logic [2:0]           in_lane,
    input  logic [7:0]           in_data,
    input  logic                 capture,
    input  logic                 park,
    input  logic                 unpark,
    input  logic                 clear,
    output logic [DDRAM_AW-1:0]  buf_addr,
    output logic [DDRAM_DW-1:0]  buf_data,
    output logic [DDRAM_BEW-1:0] buf_mask,
    output logic                 buf_empty,
    output logic                 same_word,
    output logic                 skid_full
);

    logic [DDRAM_AW-1:0] skid_addr;
    logic [2:0]          skid_lane;
    logic [7:0]          skid_data;

    function automatic logic [DDRAM_DW-1:0] put_byte(
        input logic [DDRAM_DW-1:0] word,
        input logic [2:0]          lane,
        input logic [7:0]          b
    );
        logic [DDRAM_DW-1:0] w;
        w = word;
        w[{lane, 3'b000} +: 8] = b;
        return w;
    endfunction

    function automatic logic [DDRAM_BEW-1:0] lane_bit(input logic [2:0] lane);
        return 8'd1 << lane;
    endfunction

    assign buf_empty = ~|buf_mask;
    assign same_word = (in_addr == buf_addr);

    // A fresh word always starts from zero so unwritten lanes never leak stale data.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_mask  <= '0;
            skid_addr <= '0;
            skid_lane <= '0;
            skid_data <= '0;
            skid_full <= 1'b0;
        end else begin
            if (clear || unpark) begin
                if (skid_full) begin
                    buf_addr  <= skid_addr;
                    buf_data  <= put_byte('0, skid_lane, skid_data);
                    buf_mask  <= lane_bit(skid_lane);
                    skid_full <= 1'b0;
                end else begin
                    buf_data <= '0;
                    buf_mask <= '0;
                end
            end else if (capture) begin
                if (buf_empty) begin
                    buf_addr <= in_addr;
                    buf_data <= put_byte('0, in_lane, in_data);
                    buf_mask <= lane_bit(in_lane);
                end else begin
                    buf_data <= put_byte(buf_data, in_lane, in_data);
                    buf_mask <= buf_mask | lane_bit(in_lane);
                end
            end

            if (park && !skid_full) begin
                skid_addr <= in_addr;
                skid_lane <= in_lane;
                skid_data <= in_data;
                skid_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddram_rom_writer.sv
// Write side of the DDRAM ROM channel: turns the PCM part of the ROM download
// into single-beat 64-bit DDRAM writes, stalling hps_io while a write is pending.
module ddram_rom_writer
    import ddram_pkg::*;
#(
    parameter logic [24:0] REGION_START = 25'h0A0000,
    parameter logic [24:0] REGION_SIZE  = 25'h40000,
    parameter logic [28:0] BASE_WORD    = 29'h0600000,
    parameter logic [7:0]  ROM_INDEX    = 8'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        ddram_busy,
    output logic        ddram_we,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic [7:0]  ddram_burstcnt,
    output logic        done
);

    state_t state;
    state_t state_next;
    logic   dl_prev;

    logic [24:0]         off;
    logic                in_window;
    logic                hit;
    logic [DDRAM_AW-1:0] in_addr;
    logic [2:0]          in_lane;

    logic                 capture;
    logic                 park;
    logic                 unpark;
    logic                 clear;
    logic [DDRAM_AW-1:0]  buf_addr;
    logic [DDRAM_DW-1:0]  buf_data;
    logic [DDRAM_BEW-1:0] buf_mask;
    logic                 buf_empty;
    logic                 same_word;
    logic                 skid_full;

    // The offset compare avoids overflow when the window sits near the top of the space.
    assign off       = ioctl_addr - REGION_START;
    assign in_window = (ioctl_addr >= REGION_START) && (off < REGION_SIZE);
    assign hit       = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX) && in_window;
    assign in_addr   = word_addr(BASE_WORD, off[24:3]);
    assign in_lane   = off[2:0];

    ddram_rom_writer_byte_packer u_packer (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .in_addr   (in_addr),
        .in_lane   (in_lane),
        .in_data   (ioctl_dout),
        .capture   (capture),
        .park      (park),
        .unpark    (unpark),
        .clear     (clear),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .buf_mask  (buf_mask),
        .buf_empty (buf_empty),
        .same_word (same_word),
        .skid_full (skid_full)
    );

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        park       = 1'b0;
        unpark     = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (ioctl_download && !dl_prev && (ioctl_index == ROM_INDEX))
                    state_next = COLLECT;
            end
            COLLECT: begin
                if (skid_full) begin
                    unpark = 1'b1;
                end else if (buf_mask[7]) begin
                    // A lane-7 byte arrived via the skid slot; flush it like any other.
                    park       = hit;
                    state_next = WRITE;
                end else if (hit) begin
                    if (buf_empty || same_word) begin
                        capture = 1'b1;
                        if (in_lane == 3'd7)
                            state_next = WRITE;
                    end else begin
                        park       = 1'b1;
                        state_next = WRITE;
                    end
                end else if (!ioctl_download) begin
                    state_next = buf_empty ? FINISH : WRITE;
                end
            end
            WRITE: begin
                park = hit;
                if (!ddram_busy) begin
                    clear      = 1'b1;
                    state_next = (!ioctl_download && !skid_full) ? FINISH : COLLECT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            dl_prev <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            dl_prev <= ioctl_download;
            if (state == IDLE && state_next == COLLECT)
                done <= 1'b0;
            else if (state == FINISH)
                done <= 1'b1;
        end
    end

    // Payload comes straight from the buffer, which only changes on write acceptance.
    assign ddram_we       = (state == WRITE);
    assign ddram_addr     = buf_addr;
    assign ddram_din      = buf_data;
    assign ddram_be       = buf_mask;
    assign ddram_burstcnt = 8'd1;
    assign ioctl_wait     = (state == WRITE) || skid_full;

    // A strobe while the skid slot is occupied means the host ignored ioctl_wait.
    assert property (@(posedge clk_sys) disable iff (reset) !(hit && skid_full));

endmodule
